load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory interface. Accepts one RV32 load/store per handshake, converts byte addresses
//  to word indices and drives mem_read/mem_write/address/write_data. Performs read-modify-write for SB/SH (memory is
//  word-only) and sign/zero-extends LB/LH/LBU/LHU. Sits between the execute stage and the 1024x32 data memory.
// PARAMETERS
//  ADDR_WIDTH  10  word-index width driven on mem_addr (memory depth = 2**ADDR_WIDTH words)
// PORTS
//  clk         in   1   single clock, all state updates on posedge
//  rst         in   1   asynchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   unit can accept (high only in IDLE)
//  req_store   in   1   1=store, 0=load
//  req_funct3  in   3   RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data (low byte/half used for SB/SH)
//  resp_valid  out  1   response present
//  resp_ready  in   1   consumer accepts response
//  resp_data   out  32  extended load data; 0 for stores and errors
//  resp_err    out  1   misaligned, out-of-range or illegal funct3
//  mem_read    out  1   memory read enable (rdata sampled same cycle, memory read is combinational)
//  mem_write   out  1   memory write enable (memory writes on posedge)
//  mem_addr    out  ADDR_WIDTH  word index = captured req_addr[ADDR_WIDTH+1:2]
//  mem_wdata   out  32  word to write
//  mem_rdata   in   32  word read back
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1 after reset release; resp_valid, resp_err, mem_read, mem_write=0; resp_data,
//   mem_addr, mem_wdata=0. Reset mid-operation abandons the access; no write is issued afterwards.
//  Accept: req_valid&&req_ready at posedge registers addr, wdata, funct3, store; next state by decode:
//   error (addr[0]!=0 for H/HU; addr[1:0]!=0 for W; addr[31:ADDR_WIDTH+2]!=0; funct3 not listed; BU/HU store) -> RESP, err=1, no memory cycle.
//   load -> LD; SW -> ST_WR with merge=wdata; SB/SH -> ST_RD.
//  LD: mem_read=1; capture ext(mem_rdata) into resp_data; -> RESP. Lane = addr[1:0] (byte) / addr[1] (half).
//   B/H sign-extend bit 7/15 of the selected lane; BU/HU zero-extend; W passes through.
//  ST_RD: mem_read=1; merge = mem_rdata with selected byte/half replaced by wdata[7:0]/[15:0]; -> ST_WR.
//  ST_WR: mem_write=1, mem_wdata=merge, mem_addr held; -> RESP.
//  RESP: resp_valid=1 with resp_data/resp_err stable until resp_ready; on resp_ready -> IDLE (req_ready=1 next cycle).
//  Latency accept->resp_valid: LD 2, SW 2, SB/SH 3, error 1 cycles. No back-to-back overlap: one outstanding op.
//  mem_read and mem_write are never high together; both 0 in IDLE, RESP and on error paths.
//  mem_addr/mem_wdata are registered outputs of the captured request, stable while enables are high.
//  req inputs are ignored outside IDLE; resp_ready ignored outside RESP.
// STRUCTURE
//  Shared include lsu_defs.vh: funct3 localparams (F3_B/H/W/BU/HU), state encodings (IDLE, LD, ST_RD, ST_WR, RESP).
//  Sub-module lsu_align (combinational): load lane extract + extend, store lane merge, misalign/range check.
//  Top: registered FSM, request capture registers, response registers.
// TESTING (bench instantiates the team's data memory block as the responder)
//  SW addr 0x0000_0010 data 0xDEAD_BEEF, then LW 0x10 -> mem_addr=4 write once; resp_data=0xDEAD_BEEF, err=0, latency 2.
//  Word 4 = 0x1122_3344; SB addr 0x12 data 0xAB -> one read then one write of 0x11AB_3344; LBU 0x12 -> 0x0000_00AB.
//  Word 5 = 0x8000_7F80: LB 0x14 -> 0xFFFF_FF80; LBU 0x14 -> 0x80; LH 0x16 -> 0xFFFF_8000; LHU 0x16 -> 0x8000.
//  LW 0x13, SH 0x15, LW 0x0000_1000, SBU funct3 100 store -> resp_err=1 after 1 cycle, mem_read/mem_write never asserted.
//  Hold resp_ready=0 for 5 cycles after LW -> resp_valid/resp_data stable, req_ready=0, new req_valid ignored.
//  Assert rst during ST_RD of SB -> all outputs 0 immediately, memory word unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and the
// captured-request record.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LD    = 3'd1,
    ST_RD = 3'd2,
    ST_WR = 3'd3,
    RESP  = 3'd4
  } lsu_state_t;

  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/load_store_unit_align.sv
// Lane logic: load extract/extend, store byte/half merge, misalign/range/funct3 check.
// Latency: purely combinational.
// Backpressure: none; evaluated on whatever request the top presents.
module load_store_unit_align
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  lsu_req_t    req,
  input  logic [31:0] mem_rdata,
  output logic        err,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        range_err;
  logic        fmt_err;

  // Byte address bits above the word-index field must be clear
  assign range_err = (req.addr >> (ADDR_WIDTH + 2)) != 32'd0;
  assign err       = range_err | fmt_err;

  always_comb begin
    lane_b = mem_rdata[7:0];
    case (req.addr[1:0])
      2'd0: lane_b = mem_rdata[7:0];
      2'd1: lane_b = mem_rdata[15:8];
      2'd2: lane_b = mem_rdata[23:16];
      2'd3: lane_b = mem_rdata[31:24];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = req.addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    load_data = mem_rdata;
    case (req.funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'd0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    merge_data = mem_rdata;
    case (req.funct3)
      F3_B: begin
        case (req.addr[1:0])
          2'd0: merge_data[7:0]   = req.wdata[7:0];
          2'd1: merge_data[15:8]  = req.wdata[7:0];
          2'd2: merge_data[23:16] = req.wdata[7:0];
          2'd3: merge_data[31:24] = req.wdata[7:0];
          default: merge_data = mem_rdata;
        endcase
      end
      F3_H: begin
        if (req.addr[1]) merge_data[31:16] = req.wdata[15:0];
        else             merge_data[15:0]  = req.wdata[15:0];
      end
      default: merge_data = req.wdata;
    endcase
  end

  // Unsigned variants exist only for loads
  always_comb begin
    fmt_err = 1'b1;
    case (req.funct3)
      F3_B:    fmt_err = 1'b0;
      F3_BU:   fmt_err = req.store;
      F3_H:    fmt_err = req.addr[0];
      F3_HU:   fmt_err = req.addr[0] | req.store;
      F3_W:    fmt_err = |req.addr[1:0];
      default: fmt_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one RV32 load/store per handshake, RMW for SB/SH, load extension.
// Latency accept->resp_valid: error 1, LD/SW 2, SB/SH 3 cycles; one op outstanding.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  lsu_state_t  state, state_nx;
  lsu_req_t    req_in, req_q, req_cur;
  logic        accept;
  logic        align_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign req_in = '{store: req_store, funct3: req_funct3, addr: req_addr, wdata: req_wdata};

  // Decode the incoming request while idle, the captured one afterwards
  assign req_cur = (state == IDLE) ? req_in : req_q;

  load_store_unit_align #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_align (
    .req       (req_cur),
    .mem_rdata (mem_rdata),
    .err       (align_err),
    .load_data (load_data),
    .merge_data(merge_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid) begin
          accept = 1'b1;
          if (align_err)                    state_nx = RESP;
          else if (!req_store)              state_nx = LD;
          else if (req_funct3 == F3_W)      state_nx = ST_WR;
          else                              state_nx = ST_RD;
        end
      end
      LD: begin
        mem_read = 1'b1;
        state_nx = RESP;
      end
      ST_RD: begin
        mem_read = 1'b1;
        state_nx = ST_WR;
      end
      ST_WR: begin
        mem_write = 1'b1;
        state_nx  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (accept) begin
        req_q     <= req_in;
        mem_addr  <= req_addr[ADDR_WIDTH+1:2];
        mem_wdata <= req_wdata;
        resp_data <= '0;
        resp_err  <= align_err;
      end
      if (state == LD)    resp_data <= load_data;
      // Merged word replaces the raw store data before the write cycle
      if (state == ST_RD) mem_wdata <= merge_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases then random ops against a byte-level memory model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_store;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_data;
  logic          resp_err, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0]   mem     [0:1023];
  logic [31:0]   ref_mem [0:1023];
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  int            both_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory responder: combinational read, write on posedge
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) begin
      wr_cnt <= wr_cnt + 1;
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    if (mem_read || mem_write) last_addr <= mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    if (f3 == 3'b010) return 4;
    return 0;
  endfunction

  function automatic logic model_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int size;
    size = op_size(f3);
    if (size == 0) return 1'b1;
    if (a >= 32'd4096) return 1'b1;
    if (size == 2 && a[0]) return 1'b1;
    if (size == 4 && a[1:0] != 2'd0) return 1'b1;
    if (st && f3[2]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int hold);
    int          size, sh, lat, rd0, wr0, both0, exp_lat, exp_rd, exp_wr;
    logic        exp_err;
    logic [9:0]  idx;
    logic [31:0] w, v, mask, nw;
    size    = op_size(f3);
    exp_err = model_err(st, f3, a);
    idx     = a[11:2];
    sh      = 8 * int'(a[1:0]);
    w       = ref_mem[idx];
    v       = 32'd0;
    nw      = w;
    if (!exp_err && !st) begin
      if (size == 1) begin
        v = (w >> sh) & 32'hFF;
        if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = (w >> sh) & 32'hFFFF;
        if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else v = w;
    end
    if (!exp_err && st) begin
      mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
      mask = mask << sh;
      nw   = (w & ~mask) | ((wd << sh) & mask);
    end
    exp_lat = exp_err ? 1 : (st && size < 4) ? 3 : 2;
    exp_rd  = (exp_err || (st && size == 4)) ? 0 : 1;
    exp_wr  = (!exp_err && st) ? 1 : 0;

    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    rd0 = rd_cnt; wr0 = wr_cnt; both0 = both_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    check("latency", lat, exp_lat);
    check("resp_data", resp_data, v);
    check("resp_err", 32'(resp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_W; req_addr = 32'h0; req_wdata = 32'h0BAD_F00D;
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_data", resp_data, v);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("rd_count", rd_cnt - rd0, exp_rd);
    check("wr_count", wr_cnt - wr0, exp_wr);
    check("rd_wr_overlap", both_cnt - both0, 0);
    if (exp_rd + exp_wr > 0) check("mem_addr", 32'(last_addr), 32'(idx));
    if (exp_wr > 0) begin
      ref_mem[idx] = nw;
      check("mem_word", mem[idx], nw);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [2:0]  f3_tab [0:7];
    logic [2:0]  f3;
    logic [31:0] a;
    int          wr0;
    f3_tab[0] = F3_B; f3_tab[1] = F3_H; f3_tab[2] = F3_W; f3_tab[3] = F3_BU;
    f3_tab[4] = F3_HU; f3_tab[5] = 3'b011; f3_tab[6] = 3'b110; f3_tab[7] = 3'b111;

    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // Preload words 0..15 so every later load has a known value
    for (int i = 0; i < 16; i++) do_op(1'b1, F3_W, 32'(i * 4), $urandom, 0);

    do_op(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 0);
    do_op(1'b0, F3_W, 32'h10, 32'h0, 0);
    do_op(1'b1, F3_W, 32'h10, 32'h1122_3344, 0);
    do_op(1'b1, F3_B, 32'h12, 32'h0000_00AB, 0);
    check("sb_merge_word", mem[4], 32'h11AB_3344);
    do_op(1'b0, F3_BU, 32'h12, 32'h0, 0);
    do_op(1'b1, F3_W, 32'h14, 32'h8000_7F80, 0);
    do_op(1'b0, F3_B, 32'h14, 32'h0, 0);
    do_op(1'b0, F3_BU, 32'h14, 32'h0, 0);
    do_op(1'b0, F3_H, 32'h16, 32'h0, 0);
    do_op(1'b0, F3_HU, 32'h16, 32'h0, 0);
    do_op(1'b0, F3_W, 32'h13, 32'h0, 0);
    do_op(1'b1, F3_H, 32'h15, 32'h1234, 0);
    do_op(1'b0, F3_W, 32'h0000_1000, 32'h0, 0);
    do_op(1'b1, F3_BU, 32'h10, 32'h55, 0);
    do_op(1'b0, F3_W, 32'h14, 32'h0, 5);

    // Reset while the SB read cycle is in progress
    wr0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_B; req_addr = 32'h12; req_wdata = 32'h5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw_read_phase", 32'(mem_read), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_mem_read", 32'(mem_read), 32'd0);
    check("midrst_mem_write", 32'(mem_write), 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_resp_data", resp_data, 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check("midrst_mem_wdata", mem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_no_write", wr_cnt - wr0, 0);
    check("midrst_word", mem[4], ref_mem[4]);

    for (int n = 0; n < 80; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      f3  = (sel > 7) ? F3_W : f3_tab[sel];
      if ($urandom_range(0, 15) == 0) a = $urandom | 32'h0000_1000;
      else begin
        a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 2) != 0) begin
          if (op_size(f3) == 2) a[0] = 1'b0;
          if (op_size(f3) == 4) a[1:0] = 2'b00;
        end
      end
      do_op(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
